pwm_bank: RTL and testbench
===========================

Name: pwm_bank

Overview:
- Parametrised N-channel PWM generator; next generation of the per-motor pwm instances driven from the SPI command decoder.
- Adds three things: an internal 1 us prescaler replacing the divided pwmCLK toggle flop, shadowed period/uptime registers committed glitch-free at period boundaries, and per-channel enable with period-start strobes.
- Sits between the SPI command decode (set PWM period/uptime commands) and the GPIO/motor pins, all in the GCLK domain.

Parameters:
- NUM_CH, 3, number of PWM channels (1..32).
- CNT_W, 21, width of period/uptime/counter in ticks.
- PRESCALE, 50, clk cycles per tick (1 us at 50 MHz); must be >= 1.
- DEF_PERIOD, 20000, reset value of every period register (shadow and active).

Ports:
- clk  in  1  GCLK domain clock.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  one-cycle write strobe.
- wr_sel  in  1  0 = uptime, 1 = period.
- wr_ch  in  5  target channel index.
- wr_data  in  CNT_W  value to write into the shadow register.
- wr_err  out  1  one-cycle pulse when wr_ch >= NUM_CH.
- ch_en  in  NUM_CH  per-channel enable.
- sig  out  NUM_CH  registered PWM outputs.
- pstart  out  NUM_CH  one-cycle strobe at each period commit.

Behaviour:
- Reset (async assert, sync release): prescaler=0; all counters=0; shadow and active period=DEF_PERIOD; shadow and active uptime=0; sig=0; pstart=0; wr_err=0.
- Prescaler: counts 0..PRESCALE-1 on every clk; tick=1 in the cycle it equals PRESCALE-1, then it wraps to 0. With PRESCALE=1, tick is high every cycle. A single prescaler is shared by all channels.
- Writes:
  - wr_en with wr_ch < NUM_CH loads shadow_period or shadow_uptime next edge.
  - wr_ch >= NUM_CH leaves all state untouched and pulses wr_err next cycle.
  - Writes never alter active values directly.
- Channel counter, when ch_en=1: on tick, if cnt == active_period-1 (or active_period==0), then cnt<=0, active_period<=shadow_period, active_uptime<=shadow_uptime, pstart<=1 for one clk; otherwise cnt<=cnt+1.
- Write and commit in the same cycle: the commit takes the old shadow value; the new value lands in shadow and commits at the next boundary.
- Output: sig<=ch_en && (active_period!=0) && (cnt < active_uptime), registered, so one clk after cnt.
  - uptime >= period gives a constant high.
  - uptime=0 gives a constant low.
  - period=0 gives low, with pstart on every tick.
- ch_en=0: cnt held at 0; sig=0 next cycle; shadow is copied to active every cycle; no pstart.
- ch_en 0->1: counting starts at cnt=0 with the already-current values. The first pstart occurs at the end of the first full period.
- Counter arithmetic is CNT_W-bit unsigned. cnt never exceeds active_period-1, so there is no wrap except the commit.
- Reset asserted mid-period forces all outputs low immediately (async).

Optional Feature:
- PWM_CENTER_EN.
- Defined: each channel gains a direction bit and counts up 0..P-1, then down P-1..0, giving a full cycle of 2P ticks.
  - Commit and pstart occur only at the bottom (cnt==0 while counting down, on tick).
  - sig = cnt < active_uptime, producing a centre-aligned pulse of 2*uptime ticks.
  - P==1 toggles nothing and commits every 2 ticks.
- Undefined: edge-aligned behaviour as above; the direction logic is absent.

Decomposition:
- Shared package pwm_pkg:
  - typedef pwm_cnt_t (logic [CNT_W-1:0]; default 21).
  - localparams WR_UPTIME=1'b0 and WR_PERIOD=1'b1, matching SPI command codes 0 and 2.
  - DEF_PERIOD_US=20000.
- Sub-module pwm_channel: one shadow/active/counter/output slice taking tick, wr strobes and en. pwm_bank holds the prescaler, write decode and wr_err, and instantiates NUM_CH pwm_channel in a generate loop.

Test Plan (PRESCALE=2 for bench speed):
- Reset then ch_en=001, write period=10, uptime=3 on ch0 -> sig[0] stays at the DEF_PERIOD/0 values until the first boundary (20000 ticks); afterwards sig[0] is high 3 ticks (6 clk) of every 10 ticks (20 clk), with one pstart per 20 clk.
- Mid-period, write uptime=7 -> the current period is unchanged; the new duty applies from the cycle after the next pstart; no runt or extended pulse.
- Uptime=12, period=10 -> sig constant 1. Uptime=0 -> constant 0. Period=0 -> sig 0 and pstart every 2 clk.
- wr_ch=5 with NUM_CH=3 -> wr_err pulses one cycle; all shadows are unchanged (checked by reading sig timing).
- Write coincident with the commit cycle -> the old shadow commits; the new value appears one period later.
- Reset asserted while sig=1 -> sig=0 with no clk edge; release -> DEF_PERIOD/0 state.
- PWM_CENTER_EN defined, period=4, uptime=2 -> cnt sequence 0,1,2,3,3,2,1,0; sig high for cnt 0,1 on both slopes; pstart once per 8 ticks.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : pwm_pkg                                                     |
// | Purpose  : shared types and command codes for the pwm_bank PWM slice.  |
// | Options  : PWM_CENTER_EN selects centre-aligned counting in channels.  |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
package pwm_pkg;

   localparam int PWM_CNT_W = 21;
   typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

   // wr_sel encoding mirrors the SPI set-uptime (0) / set-period (2) commands
   localparam logic WR_UPTIME = 1'b0;
   localparam logic WR_PERIOD = 1'b1;

   localparam int DEF_PERIOD_US = 20000;

endpackage
`default_nettype wire

// File: rtl/pwm_bank_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : pwm_bank_if                                                 |
// | Purpose  : shadow-register write port, channel enables and PWM outputs.|
// | Options  : none (PWM_CENTER_EN does not change this interface).        |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
interface pwm_bank_if #(
   parameter int NUM_CH = 3,
   parameter int CNT_W  = 21
);
   logic              wr_en;
   logic              wr_sel;
   logic [4:0]        wr_ch;
   logic [CNT_W-1:0]  wr_data;
   logic              wr_err;
   logic [NUM_CH-1:0] ch_en;
   logic [NUM_CH-1:0] sig;
   logic [NUM_CH-1:0] pstart;

   modport master (
      output wr_en, wr_sel, wr_ch, wr_data, ch_en,
      input  wr_err, sig, pstart
   );

   modport slave (
      input  wr_en, wr_sel, wr_ch, wr_data, ch_en,
      output wr_err, sig, pstart
   );
endinterface
`default_nettype wire

// File: rtl/pwm_bank_channel.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : pwm_channel                                                 |
// | Purpose  : one PWM slice: shadow/active registers, counter, output.    |
// | Options  : PWM_CENTER_EN -> up/down counting, commit at the bottom.    |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module pwm_channel #(
   parameter int CNT_W      = 21,
   parameter int DEF_PERIOD = 20000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_i,
   input  logic             en_i,
   input  logic             wr_up_i,
   input  logic             wr_per_i,
   input  logic [CNT_W-1:0] wr_data_i,
   output logic             sig_o,
   output logic             pstart_o
);
   localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD);

   logic [CNT_W-1:0] shadow_per_q, shadow_per_d;
   logic [CNT_W-1:0] shadow_up_q, shadow_up_d;
   logic [CNT_W-1:0] act_per_q, act_per_d;
   logic [CNT_W-1:0] act_up_q, act_up_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sig_q, sig_d;
   logic             pstart_q, pstart_d;
   logic             commit;
`ifdef PWM_CENTER_EN
   logic             dir_q, dir_d;
`endif

   always_comb begin
      shadow_per_d = shadow_per_q;
      shadow_up_d  = shadow_up_q;
      act_per_d    = act_per_q;
      act_up_d     = act_up_q;
      cnt_d        = cnt_q;
      pstart_d     = 1'b0;
      commit       = 1'b0;
`ifdef PWM_CENTER_EN
      dir_d        = dir_q;
`endif
      sig_d = en_i && (act_per_q != '0) && (cnt_q < act_up_q);

      if (!en_i) begin
         // Disabled channels track the shadows so re-enable starts on fresh values
         cnt_d     = '0;
         act_per_d = shadow_per_q;
         act_up_d  = shadow_up_q;
`ifdef PWM_CENTER_EN
         dir_d     = 1'b0;
`endif
      end else if (tick_i) begin
`ifdef PWM_CENTER_EN
         if (act_per_q == '0) begin
            commit = 1'b1;
         end else if (!dir_q) begin
            if (cnt_q == act_per_q - CNT_W'(1)) dir_d = 1'b1;
            else                                 cnt_d = cnt_q + CNT_W'(1);
         end else if (cnt_q == '0) begin
            commit = 1'b1;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
`else
         if ((act_per_q == '0) || (cnt_q == act_per_q - CNT_W'(1))) commit = 1'b1;
         else                                                        cnt_d  = cnt_q + CNT_W'(1);
`endif
      end

      if (commit) begin
         cnt_d     = '0;
         act_per_d = shadow_per_q;
         act_up_d  = shadow_up_q;
         pstart_d  = 1'b1;
`ifdef PWM_CENTER_EN
         dir_d     = 1'b0;
`endif
      end

      // Shadow loads after the commit so a same-cycle write waits one period
      if (wr_up_i)  shadow_up_d  = wr_data_i;
      if (wr_per_i) shadow_per_d = wr_data_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_per_q <= RST_PERIOD;
         shadow_up_q  <= '0;
         act_per_q    <= RST_PERIOD;
         act_up_q     <= '0;
         cnt_q        <= '0;
         sig_q        <= 1'b0;
         pstart_q     <= 1'b0;
`ifdef PWM_CENTER_EN
         dir_q        <= 1'b0;
`endif
      end else begin
         shadow_per_q <= shadow_per_d;
         shadow_up_q  <= shadow_up_d;
         act_per_q    <= act_per_d;
         act_up_q     <= act_up_d;
         cnt_q        <= cnt_d;
         sig_q        <= sig_d;
         pstart_q     <= pstart_d;
`ifdef PWM_CENTER_EN
         dir_q        <= dir_d;
`endif
      end
   end

   assign sig_o    = sig_q;
   assign pstart_o = pstart_q;

endmodule
`default_nettype wire

// File: rtl/pwm_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : pwm_bank                                                    |
// | Purpose  : N-channel PWM bank with shared 1 us prescaler, write decode.|
// | Options  : PWM_CENTER_EN -> centre-aligned channels.                   |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module pwm_bank
   import pwm_pkg::*;
#(
   parameter int NUM_CH     = 3,
   parameter int CNT_W      = PWM_CNT_W,
   parameter int PRESCALE   = 50,
   parameter int DEF_PERIOD = DEF_PERIOD_US
) (
   input  logic       clk,
   input  logic       reset,
   pwm_bank_if.slave  bus
);
   localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [5:0]      CH_LIMIT = 6'(NUM_CH);

   logic [PS_W-1:0]   prescale_q, prescale_d;
   logic              tick;
   logic              wr_err_q, wr_err_d;
   logic [NUM_CH-1:0] ch_sig;
   logic [NUM_CH-1:0] ch_pstart;

   always_comb begin
      tick       = (prescale_q == PS_LAST);
      prescale_d = tick ? '0 : prescale_q + PS_W'(1);
      wr_err_d   = bus.wr_en && ({1'b0, bus.wr_ch} >= CH_LIMIT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescale_q <= '0;
         wr_err_q   <= 1'b0;
      end else begin
         prescale_q <= prescale_d;
         wr_err_q   <= wr_err_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic hit;
      assign hit = bus.wr_en && (bus.wr_ch == 5'(g));

      pwm_channel #(
         .CNT_W      (CNT_W),
         .DEF_PERIOD (DEF_PERIOD)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .tick_i     (tick),
         .en_i       (bus.ch_en[g]),
         .wr_up_i    (hit && (bus.wr_sel == WR_UPTIME)),
         .wr_per_i   (hit && (bus.wr_sel == WR_PERIOD)),
         .wr_data_i  (bus.wr_data),
         .sig_o      (ch_sig[g]),
         .pstart_o   (ch_pstart[g])
      );
   end

   assign bus.wr_err = wr_err_q;
   assign bus.sig    = ch_sig;
   assign bus.pstart = ch_pstart;

endmodule
`default_nettype wire

// File: tb/tb_pwm_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_pwm_bank                                                 |
// | Purpose  : directed + random stimulus against a tick-level PWM model.  |
// | Options  : PWM_CENTER_EN switches the model to triangle counting.      |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_pwm_bank;
   localparam int NUM_CH     = 3;
   localparam int CNT_W      = 21;
   localparam int PRESCALE   = 2;
   localparam int DEF_PERIOD = 20000;
`ifdef PWM_CENTER_EN
   localparam bit CENTER = 1'b1;
`else
   localparam bit CENTER = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   pwm_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   pwm_bank #(
      .NUM_CH     (NUM_CH),
      .CNT_W      (CNT_W),
      .PRESCALE   (PRESCALE),
      .DEF_PERIOD (DEF_PERIOD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: each channel walks a position 0..L-1 through its period in ticks
   longint            m_cyc;
   longint            m_sh_per [NUM_CH];
   longint            m_sh_up  [NUM_CH];
   longint            m_per    [NUM_CH];
   longint            m_up     [NUM_CH];
   longint            m_pos    [NUM_CH];
   logic [NUM_CH-1:0] m_sig;
   logic [NUM_CH-1:0] m_pst;
   logic              m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cyc = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_sh_per[c] = DEF_PERIOD;
         m_sh_up[c]  = 0;
         m_per[c]    = DEF_PERIOD;
         m_up[c]     = 0;
         m_pos[c]    = 0;
      end
      m_sig = '0;
      m_pst = '0;
      m_err = 1'b0;
   endtask

   task automatic model_edge();
      bit                tick;
      logic [NUM_CH-1:0] nsig;
      logic [NUM_CH-1:0] npst;
      tick = ((m_cyc % PRESCALE) == PRESCALE - 1);
      m_cyc++;
      for (int c = 0; c < NUM_CH; c++) begin
         longint p, len, cnt;
         p   = m_per[c];
         len = CENTER ? 2 * p : p;
         cnt = (CENTER && m_pos[c] >= p) ? (2 * p - 1 - m_pos[c]) : m_pos[c];
         nsig[c] = bus.ch_en[c] && (p != 0) && (cnt < m_up[c]);
         npst[c] = 1'b0;
         if (!bus.ch_en[c]) begin
            m_pos[c] = 0;
            m_per[c] = m_sh_per[c];
            m_up[c]  = m_sh_up[c];
         end else if (tick) begin
            if (p == 0 || m_pos[c] == len - 1) begin
               m_pos[c] = 0;
               m_per[c] = m_sh_per[c];
               m_up[c]  = m_sh_up[c];
               npst[c]  = 1'b1;
            end else begin
               m_pos[c]++;
            end
         end
         if (bus.wr_en && int'(bus.wr_ch) == c) begin
            if (bus.wr_sel) m_sh_per[c] = longint'(bus.wr_data);
            else            m_sh_up[c]  = longint'(bus.wr_data);
         end
      end
      m_sig = nsig;
      m_pst = npst;
      m_err = bus.wr_en && (int'(bus.wr_ch) >= NUM_CH);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("sig",    32'(bus.sig),    32'(m_sig));
      chk("pstart", 32'(bus.pstart), 32'(m_pst));
      chk("wr_err", 32'(bus.wr_err), 32'(m_err));
   endtask

   task automatic write(input int ch, input bit sel, input int data);
      bus.wr_en   = 1'b1;
      bus.wr_ch   = 5'(ch);
      bus.wr_sel  = sel;
      bus.wr_data = CNT_W'(data);
      cycle();
      bus.wr_en   = 1'b0;
   endtask

   task automatic window(input int n, output int hi, output int ps);
      hi = 0;
      ps = 0;
      for (int i = 0; i < n; i++) begin
         cycle();
         hi += int'(bus.sig[0]);
         ps += int'(bus.pstart[0]);
      end
   endtask

   task automatic wait_for(input string tag, input bit want_pstart, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         cycle();
         seen = want_pstart ? bus.pstart[0] : bus.sig[0];
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   function automatic int exp_high(input int win, input int p, input int u);
      int len, hi;
      if (p == 0) return 0;
      len = CENTER ? 2 * p : p;
      hi  = (u >= p ? p : u) * (CENTER ? 2 : 1);
      return (win / (len * PRESCALE)) * hi * PRESCALE;
   endfunction

   function automatic int exp_pst(input int win, input int p);
      if (p == 0) return win / PRESCALE;
      return win / ((CENTER ? 2 * p : p) * PRESCALE);
   endfunction

   initial begin
      int hi, ps, r, per_clk;
      per_clk = (CENTER ? 20 : 10) * PRESCALE;
      bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_ch = '0; bus.wr_data = '0; bus.ch_en = '0;
      #1 reset = 1'b1;
      #1;
      chk("rst_async_sig",    32'(bus.sig),    32'd0);
      chk("rst_async_pstart", 32'(bus.pstart), 32'd0);
      chk("rst_async_err",    32'(bus.wr_err), 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      model_reset();

      // Default period active until the first boundary
      bus.ch_en = 3'b001;
      write(0, 1'b1, 10);
      write(0, 1'b0, 3);
      wait_for("first_boundary", 1'b1, DEF_PERIOD * PRESCALE * (CENTER ? 2 : 1) + 100);
      window(200, hi, ps);
      chk("duty3_high", 32'(hi), 32'(exp_high(200, 10, 3)));
      chk("duty3_pst",  32'(ps), 32'(exp_pst(200, 10)));

      // Mid-period duty change takes effect only after the next commit
      repeat (7) cycle();
      write(0, 1'b0, 7);
      repeat (100) cycle();
      window(200, hi, ps);
      chk("duty7_high", 32'(hi), 32'(exp_high(200, 10, 7)));

      write(0, 1'b0, 12);
      repeat (100) cycle();
      window(200, hi, ps);
      chk("up_gt_per_high", 32'(hi), 32'd200);

      write(0, 1'b0, 0);
      repeat (100) cycle();
      window(200, hi, ps);
      chk("up0_high", 32'(hi), 32'd0);

      write(0, 1'b1, 0);
      repeat (100) cycle();
      window(200, hi, ps);
      chk("per0_high", 32'(hi), 32'd0);
      chk("per0_pst",  32'(ps), 32'(exp_pst(200, 0)));

      // Out-of-range channel: error pulse, no shadow change
      write(5, 1'b1, 3);
      chk("wr_err_pulse", 32'(bus.wr_err), 32'd1);
      cycle();
      chk("wr_err_clear", 32'(bus.wr_err), 32'd0);
      window(100, hi, ps);
      chk("bad_ch_pst", 32'(ps), 32'(exp_pst(100, 0)));

      write(0, 1'b1, 10);
      write(0, 1'b0, 3);
      repeat (100) cycle();
      window(200, hi, ps);
      chk("restore_high", 32'(hi), 32'(exp_high(200, 10, 3)));

      // Write landing on the commit edge: old shadow commits first
      wait_for("sync_pstart", 1'b1, 200);
      repeat (per_clk - 1) cycle();
      write(0, 1'b0, 5);
      chk("coinc_pstart", 32'(bus.pstart[0]), 32'd1);
      window(per_clk, hi, ps);
      chk("coinc_old", 32'(hi), 32'(exp_high(per_clk, 10, 3)));
      window(per_clk, hi, ps);
      chk("coinc_new", 32'(hi), 32'(exp_high(per_clk, 10, 5)));

      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 3)       write(int'($urandom_range(0, 5)), 1'($urandom), int'($urandom_range(0, 12)));
         else if (r == 3) begin bus.ch_en = NUM_CH'($urandom); cycle(); end
         else             cycle();
      end

      // Asynchronous reset while the output is high
      bus.ch_en = 3'b001;
      write(0, 1'b1, 6);
      write(0, 1'b0, 4);
      wait_for("sig_high_before_rst", 1'b0, 200);
      #2 reset = 1'b1;
      #1;
      chk("midrst_sig",    32'(bus.sig),    32'd0);
      chk("midrst_pstart", 32'(bus.pstart), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      window(100, hi, ps);
      chk("post_rst_high", 32'(hi), 32'd0);
      chk("post_rst_pst",  32'(ps), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
